// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: E-stage forward selects, load-use/multi-cycle stalls, branch flushes and saturating stall counter for a 5-stage core
module hazard_unit_mc #(
  parameter int NUM_SRC = 2,
  parameter int REG_W = 4,
  parameter int LOAD_STALL_CYC = 1,
  parameter int EX_CYC = 4,
  parameter int CNT_W = 16,
  parameter int ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*REG_W-1:0]   SrcD,
  input  logic [NUM_SRC*REG_W-1:0]   SrcE,
  input  logic [REG_W-1:0]           DstE,
  input  logic [REG_W-1:0]           DstM,
  input  logic [REG_W-1:0]           DstW,
  input  logic                       RegWriteE,
  input  logic                       RegWriteM,
  input  logic                       RegWriteW,
  input  logic                       MemToRegE,
  input  logic                       MultiCycE,
  input  logic                       BranchTakenE,
  input  logic                       CountClr,
  output logic [2*NUM_SRC-1:0]       ForwardE,
  output logic                       StallF,
  output logic                       StallD,
  output logic                       StallE,
  output logic                       FlushD,
  output logic                       FlushE,
  output logic                       FlushM,
  output logic [CNT_W-1:0]           StallCount
);
  localparam int REM_MAX = EX_CYC > LOAD_STALL_CYC ? EX_CYC : LOAD_STALL_CYC;
  localparam int REM_W = REM_MAX > 1 ? $clog2(REM_MAX) : 1;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, EX_BUSY} state_t;
  state_t state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_haz;
  function automatic logic addr_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return a == b && !(ZERO_REG != 0 && a == '0);
  endfunction
  always_comb begin
    ForwardE = '0;
    load_haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst_n)
        ForwardE[2*i +: 2] = RegWriteM && addr_match(DstM, SrcE[i*REG_W +: REG_W]) ? 2'b10 :
                             RegWriteW && addr_match(DstW, SrcE[i*REG_W +: REG_W]) ? 2'b01 : 2'b00;
      load_haz = load_haz | addr_match(DstE, SrcD[i*REG_W +: REG_W]);
    end
    load_haz = load_haz & MemToRegE & RegWriteE;
  end
  always_comb begin
    {StallF, StallD, StallE, FlushD, FlushE, FlushM} = '0;
    state_d = state_q;
    rem_d = rem_q;
    if (rst_n)
      case (state_q)
        IDLE:
          if (BranchTakenE) {FlushD, FlushE} = '1;
          else if (MultiCycE && EX_CYC > 1) begin
            {StallF, StallD, StallE, FlushM} = '1;
            if (EX_CYC > 2) begin
              state_d = EX_BUSY;
              rem_d = REM_W'(EX_CYC - 2);
            end
          end else if (load_haz) begin
            {StallF, StallD, FlushE} = '1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = LOAD_WAIT;
              rem_d = REM_W'(LOAD_STALL_CYC - 1);
            end
          end
        LOAD_WAIT: begin
          {StallF, StallD, FlushE} = '1;
          rem_d = rem_q - REM_W'(1);
          state_d = rem_q == REM_W'(1) ? IDLE : LOAD_WAIT;
        end
        EX_BUSY: begin
          {StallF, StallD, StallE, FlushM} = '1;
          rem_d = rem_q - REM_W'(1);
          state_d = rem_q == REM_W'(1) ? IDLE : EX_BUSY;
        end
        default: state_d = IDLE;
      endcase
    cnt_d = CountClr ? '0 : StallF && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  assign StallCount = cnt_q;
endmodule
